// File: rtl/product_accumulator_if.sv
// ----------------------------------------------------------------------------
// product_accumulator_if
// Handshake bundle between the multiplier array, the product accumulator and
// the sum consumer.
//   in_valid  : producer -> accumulator, prod is valid
//   in_ready  : accumulator -> producer, a product is accepted this cycle
//   prod      : 4-bit unsigned product (0..9)
//   out_valid : accumulator -> consumer, acc_out holds a completed sum
//   out_ready : consumer -> accumulator, consumer takes acc_out
//   acc_out   : ACC_W-bit accumulated sum
// Modports: master = product source / sum sink side, slave = accumulator side.
// ACC_W must match the ACC_W of the attached product_accumulator.
// ----------------------------------------------------------------------------
interface product_accumulator_if #(
  parameter int ACC_W = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       prod;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;

  modport master (
    output in_valid, prod, out_ready,
    input  in_ready, out_valid, acc_out
  );

  modport slave (
    input  in_valid, prod, out_ready,
    output in_ready, out_valid, acc_out
  );
endinterface

// File: rtl/product_accumulator.sv
// ----------------------------------------------------------------------------
// product_accumulator
// Sums N_TERMS unsigned 4-bit products into an ACC_W-bit register and presents
// the result on an output valid/ready handshake.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : one-cycle pulse, begins a transaction (acted on only in IDLE)
//   busy   : high while accumulating or holding a result
//   ovf    : sticky overflow flag for the current transaction
//   bus    : product_accumulator_if.slave (in/out handshakes, prod, acc_out)
// Configuration:
//   PRODUCT_ACCUMULATOR_SATURATE_EN defined   -> overflow clamps to all-ones
//   PRODUCT_ACCUMULATOR_SATURATE_EN undefined -> sum wraps modulo 2^ACC_W
//   In both builds ovf records any carry-out of the add.
// ----------------------------------------------------------------------------
module product_accumulator #(
  parameter int ACC_W   = 8,
  parameter int N_TERMS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       ovf,
  product_accumulator_if.slave       bus
);

  localparam int CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [ACC_W:0]   sum_ext;

  // Full-precision add; the extra top bit is the carry-out used for ovf.
  function automatic logic [ACC_W:0] add_ext(input logic [ACC_W-1:0] a,
                                             input logic [3:0]       p);
    return {1'b0, a} + {{(ACC_W - 3){1'b0}}, p};
  endfunction

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
  function automatic logic [ACC_W-1:0] fit_acc(input logic [ACC_W:0] s);
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction
`else
  function automatic logic [ACC_W-1:0] fit_acc(input logic [ACC_W:0] s);
    return s[ACC_W-1:0];
  endfunction
`endif

  assign sum_ext       = add_ext(acc, bus.prod);
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = acc;

  // Control and outputs are all registered; next-state decisions use the
  // registered state so no input reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      count       <= '0;
      ovf         <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc        <= '0;
            count      <= '0;
            ovf        <= 1'b0;
            in_ready_q <= 1'b1;
            busy       <= 1'b1;
            state      <= ACCUM;
          end
        end
        ACCUM: begin
          // in_ready_q is 1 throughout ACCUM, so in_valid alone accepts.
          if (bus.in_valid) begin
            acc   <= fit_acc(sum_ext);
            count <= count + CNT_W'(1);
            if (sum_ext[ACC_W]) ovf <= 1'b1;
            if (count == LAST_CNT) begin
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

  typedef struct {
    int inst;
    int sum;
    int ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Index 0: ACC_W=8,N_TERMS=4   1: ACC_W=6,N_TERMS=8   2: ACC_W=8,N_TERMS=1
  logic       st   [3];
  logic       iv   [3];
  logic [3:0] pr   [3];
  logic       ordy [3];
  logic       ir   [3];
  logic       ov   [3];
  logic       bz   [3];
  logic       of   [3];
  int         ao   [3];

  logic bz0, bz1, bz2, of0, of1, of2;

  product_accumulator_if #(.ACC_W(8)) if0 ();
  product_accumulator_if #(.ACC_W(6)) if1 ();
  product_accumulator_if #(.ACC_W(8)) if2 ();

  product_accumulator #(.ACC_W(8), .N_TERMS(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .busy(bz0), .ovf(of0), .bus(if0));
  product_accumulator #(.ACC_W(6), .N_TERMS(8)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .busy(bz1), .ovf(of1), .bus(if1));
  product_accumulator #(.ACC_W(8), .N_TERMS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .busy(bz2), .ovf(of2), .bus(if2));

  always_comb begin
    if0.in_valid = iv[0]; if0.prod = pr[0]; if0.out_ready = ordy[0];
    if1.in_valid = iv[1]; if1.prod = pr[1]; if1.out_ready = ordy[1];
    if2.in_valid = iv[2]; if2.prod = pr[2]; if2.out_ready = ordy[2];
  end

  always_comb begin
    ir[0] = if0.in_ready; ov[0] = if0.out_valid; ao[0] = int'(if0.acc_out);
    ir[1] = if1.in_ready; ov[1] = if1.out_valid; ao[1] = int'(if1.acc_out);
    ir[2] = if2.in_ready; ov[2] = if2.out_valid; ao[2] = int'(if2.acc_out);
    bz[0] = bz0; bz[1] = bz1; bz[2] = bz2;
    of[0] = of0; of[1] = of1; of[2] = of2;
  end

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  int   stim[$];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int width_of(input int k);
    return (k == 1) ? 6 : 8;
  endfunction

  // Monitor: every output handshake pops one expected result.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst_n && ov[k] && ordy[k]) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_instance", k, e.inst);
          check("sb_sum", ao[k], e.sum);
          check("sb_ovf", int'(of[k]), e.ovf);
        end
      end
    end
  end

  // Reference: running unsigned sum with wrap or clamp on exceeding 2^W-1.
  task automatic push_expected(input int k, output int sum);
    int lim, r, o;
    lim = 1 << width_of(k);
    r = 0;
    o = 0;
    foreach (stim[i]) begin
      r = r + stim[i];
      if (r >= lim) begin
        o = 1;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
        r = lim - 1;
`else
        r = r - lim;
`endif
      end
    end
    sb.push_back('{inst: k, sum: r, ovf: o});
    sum = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on instance k using the products in stim.
  task automatic run_txn(input int k, input int bub_pct, input int stall,
                         input bit st_acc, input bit st_done, input bit st_hand);
    int r;
    push_expected(k, r);
    st[k] = 1'b1;
    tick();
    st[k] = 1'b0;
    check("start_in_ready", int'(ir[k]), 1);
    check("start_busy", int'(bz[k]), 1);
    check("start_clr_acc", ao[k], 0);
    check("start_clr_ovf", int'(of[k]), 0);
    foreach (stim[i]) begin
      if (int'($urandom_range(0, 99)) < bub_pct) begin
        iv[k] = 1'b0;
        pr[k] = 4'($urandom_range(0, 15));
        tick();
      end
      iv[k] = 1'b1;
      pr[k] = 4'(stim[i]);
      if (st_acc && i == 0) st[k] = 1'b1;
      tick();
      st[k] = 1'b0;
    end
    iv[k] = 1'b0;
    pr[k] = 4'($urandom_range(0, 15));
    check("done_out_valid", int'(ov[k]), 1);
    check("done_in_ready", int'(ir[k]), 0);
    check("done_busy", int'(bz[k]), 1);
    for (int s = 0; s < stall; s++) begin
      if (st_done && s == 0) st[k] = 1'b1;
      tick();
      st[k] = 1'b0;
      check("stall_out_valid", int'(ov[k]), 1);
      check("stall_acc_out", ao[k], r);
      check("stall_in_ready", int'(ir[k]), 0);
    end
    ordy[k] = 1'b1;
    if (st_hand) st[k] = 1'b1;
    tick();
    ordy[k] = 1'b0;
    st[k] = 1'b0;
    check("idle_out_valid", int'(ov[k]), 0);
    check("idle_busy", int'(bz[k]), 0);
    check("idle_acc_held", ao[k], r);
    tick();
    check("idle_stays_idle", int'(bz[k]), 0);
  endtask

  task automatic rand_stim(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(int'($urandom_range(0, 9)));
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0; iv[k] = 1'b0; pr[k] = 4'd0; ordy[k] = 1'b0;
    end
    #12;
    for (int k = 0; k < 3; k++) begin
      check("rst_in_ready", int'(ir[k]), 0);
      check("rst_out_valid", int'(ov[k]), 0);
      check("rst_busy", int'(bz[k]), 0);
      check("rst_ovf", int'(of[k]), 0);
      check("rst_acc_out", ao[k], 0);
    end
    tick();
    rst_n = 1'b1;
    tick();

    // Basic sum 9+6+4+0 = 19, back-to-back products
    stim = '{9, 6, 4, 0};
    run_txn(0, 0, 0, 1'b0, 1'b0, 1'b0);

    // Bubbles and 5-cycle backpressure, sum 9
    stim = '{1, 2, 3, 3};
    run_txn(0, 100, 5, 1'b0, 1'b0, 1'b0);

    // Start pulses during ACCUM, DONE and at the handoff are all ignored
    stim = '{7, 8, 9, 5};
    run_txn(0, 40, 3, 1'b1, 1'b1, 1'b1);

    // Overflow: eight 9s into a 6-bit accumulator
    stim = '{9, 9, 9, 9, 9, 9, 9, 9};
    run_txn(1, 0, 1, 1'b0, 1'b0, 1'b0);
    // A fresh start after an overflowing run clears ovf (checked on start)
    stim = '{1, 0, 2, 0, 3, 0, 4, 0};
    run_txn(1, 30, 0, 1'b0, 1'b0, 1'b0);

    // N_TERMS=1
    stim = '{9};
    run_txn(2, 0, 0, 1'b0, 1'b0, 1'b0);

    // Reset mid-transaction after 9+6 = 15
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    iv[0] = 1'b1; pr[0] = 4'd9;
    tick();
    pr[0] = 4'd6;
    tick();
    iv[0] = 1'b0;
    check("mid_partial_acc", ao[0], 15);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_acc_out", ao[0], 0);
    check("async_rst_busy", int'(bz[0]), 0);
    check("async_rst_in_ready", int'(ir[0]), 0);
    check("async_rst_out_valid", int'(ov[0]), 0);
    check("async_rst_ovf", int'(of[0]), 0);
    tick();
    rst_n = 1'b1;
    tick();
    stim = '{1, 1, 1, 1};
    run_txn(0, 0, 0, 1'b0, 1'b0, 1'b0);

    // Randomized transactions on every instance
    for (int n = 0; n < 6; n++) begin
      rand_stim(4);
      run_txn(0, 30, int'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
      rand_stim(8);
      run_txn(1, 30, int'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
      rand_stim(1);
      run_txn(2, 30, int'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
    end

    tick();
    tick();
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential accumulator directly downstream of the 2x2 multiplier array. It consumes a stream of 4-bit products over a valid/ready handshake and sums a fixed number of them (N_TERMS) into a wider register. It presents the finished sum on an output valid/ready handshake. Together with the multiplier it forms a small dot-product / MAC datapath.

## Interface
- ACC_W, default 8: accumulator and result width in bits; must be ≥ 4.
- N_TERMS, default 4: products summed per transaction; must be ≥ 1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle pulse that begins a transaction; sampled only in IDLE.
- in_valid  input  1  prod is valid this cycle.
- in_ready  output  1  block accepts a product this cycle.
- prod  input  4  unsigned product from the multiplier (0..9).
- out_valid  output  1  acc_out holds a completed sum.
- out_ready  input  1  consumer takes acc_out this cycle.
- acc_out  output  ACC_W  accumulated sum, registered.
- busy  output  1  high in ACCUM or DONE.
- ovf  output  1  sticky overflow flag for the current transaction.

## Operation
- States:
  - IDLE: reset state.
  - ACCUM: accepting products.
  - DONE: result held.
- IDLE:
  - in_ready=0, out_valid=0, busy=0.
  - On start=1: acc←0, count←0, ovf←0, go to ACCUM.
- ACCUM:
  - in_ready=1, busy=1.
  - A term is accepted on a cycle with in_valid & in_ready. On acceptance: acc←acc+zero-extended prod, count←count+1.
  - When the accepted term is number N_TERMS (count was N_TERMS-1): go to DONE.
  - Cycles with in_valid=0 leave acc and count unchanged.
  - prod is ignored when not accepted.
- DONE:
  - out_valid=1, in_ready=0, busy=1. acc_out stable.
  - On out_ready=1: go to IDLE; out_valid drops the next cycle.
- start is ignored in ACCUM and DONE.
- A start in the same cycle as the DONE→IDLE handoff is ignored; start is only acted on once the block is in IDLE.
- acc_out always reflects the acc register. It is held in IDLE after a transaction until the next start clears it.
- count width is the minimum needed to hold N_TERMS.
- Arithmetic is unsigned. prod is zero-extended to ACC_W before the add.
- Overflow: an add whose true result exceeds 2^ACC_W-1. Handling depends on SATURATE_EN (see Configuration).
- Reset asserted at any time, including mid-transaction: async return to IDLE. acc, count, ovf, out_valid, in_ready, busy all go to 0. A partial sum is discarded.

## Timing
- Reset values: in_ready=0, out_valid=0, busy=0, ovf=0, acc_out=0.
- start at edge k → ACCUM; in_ready=1 from cycle k+1.
- Minimum transaction with in_valid held high: N_TERMS acceptance cycles after ACCUM entry.
- out_valid rises the cycle after the last acceptance.
- Output handshake completes on the edge where out_valid & out_ready are both 1.
- Throughput: one product per cycle in ACCUM. At least one IDLE cycle separates transactions.
- All outputs are registered or decoded from state only. There are no combinational paths from in_valid, out_ready or prod to any output.

## Configuration
- Macro: PRODUCT_ACCUMULATOR_SATURATE_EN.
- Defined:
  - On overflow, acc clamps to 2^ACC_W-1 and stays there for the rest of the transaction.
  - ovf is set to 1 and is sticky until the next start or reset.
- Undefined:
  - acc wraps modulo 2^ACC_W.
  - ovf still sets on any carry-out of the add, so wrap is visible. The saturation logic is not compiled.

## Test plan
- Basic sum (defaults): reset, start, products 9,6,4,0 on consecutive cycles → out_valid one cycle after the 4th; acc_out=8'h13 (19); ovf=0; out_ready=1 → IDLE, busy=0.
- Bubbles and backpressure: start, products 1,2,3,3 interleaved with in_valid=0 gaps → acc_out=9 after the 4th accepted term; hold out_ready=0 for 5 cycles → out_valid and acc_out=9 stay stable, in_ready=0 throughout.
- Overflow, ACC_W=6, N_TERMS=8, eight products of 9 (sum 72):
  - Macro undefined → acc_out=8, ovf=1.
  - Macro defined → acc_out=63, ovf=1.
- Ignored start: pulse start during ACCUM and during DONE → sum unaffected, no restart; a later start from IDLE clears acc_out to 0 and ovf to 0.
- Reset mid-transaction: after 2 of 4 terms (acc=15), assert rst_n=0 asynchronously → all outputs 0 immediately; after release, a fresh 4-term run of 1s gives acc_out=4.
- N_TERMS=1: start, single product 9 → out_valid the next cycle with acc_out=9.
